coder_tx_serializer: RTL and testbench

CODER_TX_SERIALIZER -- requirements
Module: coax_tx

---
 rtl/coax_pkg.sv | 35 +++
 rtl/coax_bit_timer.sv | 35 +++
 rtl/coder_tx_serializer.sv | 198 +++++++++++++++++++
 tb/tb_coder_tx_serializer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/coax_pkg.sv
// Shared definitions for the coax Manchester transmitter: FSM state
// encoding, protocol segment lengths and the parity helper.
package coax_pkg;

  // Serializer phases, in the order they appear on the line.
  typedef enum logic [2:0] {
    IDLE,
    LINE_QUIESCE,
    CODE_VIOLATION,
    SYNC_BIT,
    DATA_BIT,
    PARITY_BIT,
    END_SEQUENCE
  } state_t;

  // Segment lengths in bit-times.
  localparam int unsigned QUIESCE_BITS   = 5;
  localparam int unsigned VIOLATION_BITS = 3;
  localparam int unsigned SYNC_BITS      = 1;
  localparam int unsigned WORD_BITS      = 10;
  localparam int unsigned PARITY_BITS    = 1;
  localparam int unsigned END_BITS       = 3;

  // Width of the per-segment bit counter (longest segment is a data word).
  localparam int unsigned BIT_IDX_W = 4;
  typedef logic [BIT_IDX_W-1:0] bit_idx_t;

  // Parity bit sent after each word: XOR of the word in even mode,
  // its complement in odd mode.
  function automatic logic parity_bit(input logic [WORD_BITS-1:0] word,
                                      input logic                 even_mode);
    return even_mode ? (^word) : ~(^word);
  endfunction

endpackage

// File: rtl/coax_bit_timer.sv
// Bit-time divider for the coax transmitter. While i_run is high it counts
// clk cycles within one bit-time and reports which half of the bit is on
// the line and when the last cycle of the bit is reached. Held at zero
// while idle so every frame starts exactly on a bit boundary.
module coax_bit_timer #(
  parameter int unsigned CLOCKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_run,
  output logic o_first_half,
  output logic o_bit_end
);

  localparam int unsigned CW = $clog2(CLOCKS_PER_BIT);

  logic [CW-1:0] r_cnt;

  // Cycle-within-bit counter; wraps at the end of every bit-time.
  always_ff @(posedge clk) begin
    // NOTE: clocked state is always updated with non-blocking assignments so
    // every register samples the pre-edge values of its neighbours.
    if (reset || !i_run) begin
      r_cnt <= '0;
    end else if (o_bit_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_bit_end    = (r_cnt == CW'(CLOCKS_PER_BIT - 1));
  assign o_first_half = (r_cnt <  CW'(CLOCKS_PER_BIT / 2));

endmodule

// File: rtl/coder_tx_serializer.sv
// Coax Manchester frame serializer. A frame is: line quiesce (encoded 1s),
// a 3-bit code violation, then per word a sync bit, 10 data bits MSB first
// and a parity bit, closed by an end sequence. A one-deep holding register
// lets a second word be chained into the running frame.
// Optional feature: define COAX_TX_DELAY_EN to drive tx_delay from a
// CLOCKS_PER_BIT/4 stage delay line; otherwise tx_delay is tied low.
module coder_tx_serializer
  import coax_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_BITS-1:0] data,
  input  logic                 strobe,
  input  logic                 parity,
  output logic                 tx,
  output logic                 tx_delay,
  output logic                 tx_inverted,
  output logic                 active,
  output logic                 ready
);

  state_t               r_state;
  state_t               w_next_state;
  bit_idx_t             r_bit_idx;
  bit_idx_t             w_state_bits;
  logic                 w_state_done;
  logic                 w_first_half;
  logic                 w_bit_end;
  logic                 w_tx;
  logic                 w_enc_bit;
  logic                 w_ready;
  logic                 w_accept;
  logic                 w_new_par;
  logic                 w_load_next;

  logic [WORD_BITS-1:0] r_word;
  logic                 r_par;
  logic [WORD_BITS-1:0] r_hold_data;
  logic                 r_hold_par;
  logic                 r_hold_valid;

  coax_bit_timer #(
    .CLOCKS_PER_BIT (CLOCKS_PER_BIT)
  ) u_bit_timer (
    .clk          (clk),
    .reset        (reset),
    .i_run        (r_state != IDLE),
    .o_first_half (w_first_half),
    .o_bit_end    (w_bit_end)
  );

  // Strobes are taken when idle, or mid-frame while the holding register is
  // free; never during the end sequence, which is already committed.
  assign w_ready      = (r_state == IDLE) ||
                        ((r_state != END_SEQUENCE) && !r_hold_valid);
  assign w_accept     = strobe && w_ready;
  assign w_new_par    = parity_bit(data, parity);
  assign w_state_done = w_bit_end && (r_bit_idx == (w_state_bits - bit_idx_t'(1)));
  // Last parity cycle with another word available: chain straight into SYNC_BIT.
  assign w_load_next  = (r_state == PARITY_BIT) && w_state_done &&
                        (r_hold_valid || w_accept);

  // Segment sequencing and Manchester line level.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path through
    // the case leaves it unassigned (which would infer a latch).
    w_next_state = r_state;
    w_state_bits = bit_idx_t'(1);
    w_enc_bit    = 1'b0;
    w_tx         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next_state = LINE_QUIESCE;
      end
      LINE_QUIESCE: begin
        w_state_bits = bit_idx_t'(QUIESCE_BITS);
        w_enc_bit    = 1'b1;
        w_tx         = w_first_half ? ~w_enc_bit : w_enc_bit;
        if (w_state_done) w_next_state = CODE_VIOLATION;
      end
      CODE_VIOLATION: begin
        // High for 1.5 bit-times, then low for 1.5 bit-times.
        w_state_bits = bit_idx_t'(VIOLATION_BITS);
        w_tx         = (r_bit_idx == bit_idx_t'(0)) ||
                       ((r_bit_idx == bit_idx_t'(1)) && w_first_half);
        if (w_state_done) w_next_state = SYNC_BIT;
      end
      SYNC_BIT: begin
        w_state_bits = bit_idx_t'(SYNC_BITS);
        w_enc_bit    = 1'b1;
        w_tx         = w_first_half ? ~w_enc_bit : w_enc_bit;
        if (w_state_done) w_next_state = DATA_BIT;
      end
      DATA_BIT: begin
        w_state_bits = bit_idx_t'(WORD_BITS);
        w_enc_bit    = r_word[WORD_BITS-1];
        w_tx         = w_first_half ? ~w_enc_bit : w_enc_bit;
        if (w_state_done) w_next_state = PARITY_BIT;
      end
      PARITY_BIT: begin
        w_state_bits = bit_idx_t'(PARITY_BITS);
        w_enc_bit    = r_par;
        w_tx         = w_first_half ? ~w_enc_bit : w_enc_bit;
        if (w_state_done) w_next_state = w_load_next ? SYNC_BIT : END_SEQUENCE;
      end
      END_SEQUENCE: begin
        // One encoded '0', then the line is held high.
        w_state_bits = bit_idx_t'(END_BITS);
        w_tx         = (r_bit_idx == bit_idx_t'(0)) ? w_first_half : 1'b1;
        if (w_state_done) w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Segment bit counter, current word shifter and holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the word and holding registers are cleared as well, so a word
      // aborted by reset can never reappear in a later frame.
      r_bit_idx    <= '0;
      r_word       <= '0;
      r_par        <= 1'b0;
      r_hold_data  <= '0;
      r_hold_par   <= 1'b0;
      r_hold_valid <= 1'b0;
    end else begin
      if (w_next_state != r_state) begin
        r_bit_idx <= '0;
      end else if (w_bit_end) begin
        r_bit_idx <= r_bit_idx + bit_idx_t'(1);
      end

      if (w_load_next) begin
        // Chain the next word; a strobe landing on this very cycle bypasses
        // the (empty) holding register.
        if (r_hold_valid) begin
          r_word       <= r_hold_data;
          r_par        <= r_hold_par;
          r_hold_valid <= 1'b0;
        end else begin
          r_word <= data;
          r_par  <= w_new_par;
        end
      end else if (w_accept && (r_state == IDLE)) begin
        r_word <= data;
        r_par  <= w_new_par;
      end else begin
        if ((r_state == DATA_BIT) && w_bit_end) begin
          r_word <= {r_word[WORD_BITS-2:0], 1'b0};
        end
        if (w_accept) begin
          r_hold_data  <= data;
          r_hold_par   <= w_new_par;
          r_hold_valid <= 1'b1;
        end
      end
    end
  end

`ifdef COAX_TX_DELAY_EN
  localparam int unsigned DELAY_STAGES = CLOCKS_PER_BIT / 4;

  logic [DELAY_STAGES-1:0] r_tx_dly;

  // Pre-emphasis delay line: tx shifted by a quarter bit-time.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_dly <= '0;
    end else begin
      r_tx_dly <= DELAY_STAGES'({r_tx_dly, w_tx});
    end
  end

  assign tx_delay = r_tx_dly[DELAY_STAGES-1];
`else
  assign tx_delay = 1'b0;
`endif

  assign tx          = w_tx;
  assign active      = (r_state != IDLE);
  assign tx_inverted = active & ~w_tx;
  assign ready       = w_ready;

endmodule

// File: tb/tb_coder_tx_serializer.sv
// Self-checking bench for coder_tx_serializer. Expected Manchester
// half-bit levels are queued when a strobe is driven and compared against
// tx at the middle of every half-bit while the frame is active.
module tb_coder_tx_serializer;
  import coax_pkg::*;

  localparam int CPB        = 8;
  localparam int HALF       = CPB / 2;
  localparam int END_HALVES = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] data;
  logic       strobe;
  logic       parity;
  logic       tx;
  logic       tx_delay;
  logic       tx_inverted;
  logic       active;
  logic       ready;

  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_q[$];
  bit   aborted = 1'b0;
  int   exp_len = 0;
  int   act_cyc = 0;
  bit   was_active = 1'b0;
  logic e_tx;
  logic e_inv;
  logic e_dly;

  coder_tx_serializer #(
    .CLOCKS_PER_BIT (CPB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data        (data),
    .strobe      (strobe),
    .parity      (parity),
    .tx          (tx),
    .tx_delay    (tx_delay),
    .tx_inverted (tx_inverted),
    .active      (active),
    .ready       (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected half-bit levels of one word (sync, data MSB first, parity),
  // inserted at queue position pos.
  function automatic void push_word(input logic [9:0] d, input logic p, input int pos);
    logic [11:0] bits;
    int          at;
    bits = {1'b1, d, (p ? ^d : ~^d)};
    at   = pos;
    for (int i = 11; i >= 0; i--) begin
      exp_q.insert(at, ~bits[i]); at++;
      exp_q.insert(at, bits[i]);  at++;
    end
  endfunction

  function automatic void push_frame(input logic [9:0] d, input logic p);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    end
    for (int i = 0; i < 3; i++) exp_q.push_back(1'b1);
    for (int i = 0; i < 3; i++) exp_q.push_back(1'b0);
    push_word(d, p, exp_q.size());
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(1'b1);
  endfunction

`ifdef COAX_TX_DELAY_EN
  logic [7:0] tx_hist = '0;
  always @(posedge clk) begin
    if (reset) tx_hist <= '0;
    else       tx_hist <= {tx_hist[6:0], tx};
  end
`endif

  // Line monitor: half-bit sampling, frame length and scoreboard drain.
  always @(negedge clk) begin
    if (active) begin
      if ((act_cyc % HALF) == (HALF / 2)) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'(1), 32'(0));
        end else begin
          e_tx  = exp_q.pop_front();
          e_inv = ~e_tx;
`ifdef COAX_TX_DELAY_EN
          e_dly = tx_hist[CPB/4-1];
`else
          e_dly = 1'b0;
`endif
          check("tx_half", 32'(tx), 32'(e_tx));
          check("tx_inverted", 32'(tx_inverted), 32'(e_inv));
          check("tx_delay", 32'(tx_delay), 32'(e_dly));
        end
      end
      act_cyc++;
      was_active = 1'b1;
    end else if (was_active) begin
      if (!aborted) begin
        check("frame_len", act_cyc, exp_len);
        check("sb_empty", exp_q.size(), 32'(0));
      end else begin
        exp_q.delete();
      end
      aborted    = 1'b0;
      act_cyc    = 0;
      was_active = 1'b0;
    end
  end

  // Start a frame from IDLE; data is scrambled afterwards to catch late sampling.
  task automatic start_frame(input logic [9:0] d, input logic p);
    check("ready_idle", 32'(ready), 32'(1));
    data = d; parity = p; strobe = 1'b1;
    push_frame(d, p);
    @(negedge clk);
    strobe = 1'b0; data = ~d; parity = ~p;
    check("active_rise", 32'(active), 32'(1));
  endtask

  // Strobe during a frame; exp_acc says whether the word should be chained.
  task automatic send_mid(input logic [9:0] d, input logic p, input logic exp_acc);
    check("ready_mid", 32'(ready), 32'(exp_acc));
    data = d; parity = p; strobe = 1'b1;
    if (exp_acc) push_word(d, p, exp_q.size() - END_HALVES);
    @(negedge clk);
    strobe = 1'b0; data = ~d; parity = ~p;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (active && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check("idle_in_budget", 32'(active), 32'(0));
    @(negedge clk);
    check("state_idle", 32'(dut.r_state), 32'(IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; strobe = 1'b0; data = '0; parity = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'(0));
    check("rst_active", 32'(active), 32'(0));
    check("rst_ready", 32'(ready), 32'(1));
    check("rst_tx_inverted", 32'(tx_inverted), 32'(0));
    check("rst_tx_delay", 32'(tx_delay), 32'(0));

    // One-cycle reset pulse from IDLE.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("pulse_state", 32'(dut.r_state), 32'(IDLE));
    check("pulse_tx", 32'(tx), 32'(0));
    check("pulse_ready", 32'(ready), 32'(1));

    // Single word, even parity: 23 bit-times.
    exp_len = 23 * CPB;
    start_frame(10'b0101110101, 1'b1);
    wait_idle(300);

    // Second word chained during quiesce: 35 bit-times.
    exp_len = 35 * CPB;
    start_frame(10'b0101110101, 1'b1);
    repeat (39) @(negedge clk);
    send_mid(10'b1010001110, 1'b0, 1'b1);
    wait_idle(400);

    // Strobe during the end sequence is ignored.
    exp_len = 23 * CPB;
    start_frame(10'b0101110101, 1'b1);
    repeat (165) @(negedge clk);
    send_mid(10'b1010001110, 1'b0, 1'b0);
    wait_idle(466);

    // Odd parity on an all-zero word gives a '1' parity bit.
    exp_len = 23 * CPB;
    start_frame(10'b0000000000, 1'b0);
    wait_idle(300);

    // Reset in the middle of the data bits aborts the frame.
    start_frame(10'b1100110011, 1'b1);
    repeat (89) @(negedge clk);
    aborted = 1'b1;
    reset   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_state", 32'(dut.r_state), 32'(IDLE));
    check("abort_tx", 32'(tx), 32'(0));
    check("abort_active", 32'(active), 32'(0));
    check("abort_ready", 32'(ready), 32'(1));
    check("abort_tx_inverted", 32'(tx_inverted), 32'(0));
    @(negedge clk);

    // Clean frame after the abort: no stale held word, counters restarted.
    exp_len = 23 * CPB;
    start_frame(10'b1111100000, 1'b1);
    wait_idle(300);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
